// File: rtl/conv_layer_sequencer_if.sv
// Handshake and buffer-address bundle between the layer scheduler, the conv
// layer sequencer and the tile/param/output buffers.
interface conv_layer_sequencer_if #(
  parameter int NUM_FILTERS = 8,
  parameter int NUM_TILES   = 4
);
  localparam int FILT_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int OUT_W  = (NUM_FILTERS * NUM_TILES > 1) ? $clog2(NUM_FILTERS * NUM_TILES) : 1;

  logic              start;
  logic              hold;
  logic              abort;
  logic              busy;
  logic              done;
  logic              in_rd_en;
  logic [TILE_W-1:0] in_rd_addr;
  logic              param_rd_en;
  logic [FILT_W-1:0] param_rd_addr;
  logic              out_wr_en;
  logic [OUT_W-1:0]  out_wr_addr;

  modport master (
    output start, hold, abort,
    input  busy, done, in_rd_en, in_rd_addr, param_rd_en, param_rd_addr,
           out_wr_en, out_wr_addr
  );

  modport slave (
    input  start, hold, abort,
    output busy, done, in_rd_en, in_rd_addr, param_rd_en, param_rd_addr,
           out_wr_en, out_wr_addr
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Sequences one conv layer pass: issues (filter, tile) reads, tracks tokens
// through the fixed-latency datapath and strobes the output-buffer writes.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_RUN   | issuing tokens, tile is the inner loop
// S_DRAIN | all tokens issued, waiting for the datapath to empty
// S_DONE  | one-cycle completion pulse
module conv_layer_sequencer #(
  parameter int NUM_FILTERS = 8,
  parameter int NUM_TILES   = 4,
  parameter int LAT         = 4
) (
  input logic                    clk_PL,
  input logic                    rst_n,
  conv_layer_sequencer_if.slave  bus
);
  localparam int FILT_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int OUT_W  = (NUM_FILTERS * NUM_TILES > 1) ? $clog2(NUM_FILTERS * NUM_TILES) : 1;

  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NUM_TILES - 1);
  localparam logic [OUT_W-1:0]  IDX_LAST  = OUT_W'(NUM_FILTERS * NUM_TILES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                       state_q, state_d;
  logic [FILT_W-1:0]            filt_q, filt_d;
  logic [TILE_W-1:0]            tile_q, tile_d;
  logic [OUT_W-1:0]             idx_q, idx_d;
  logic [LAT-1:0]               vld_q, vld_d;
  logic [LAT-1:0][OUT_W-1:0]    addr_q, addr_d;
  logic                         issue;
  logic [OUT_W-1:0]             new_addr;

  always_ff @(posedge clk_PL) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      filt_q  <= '0;
      tile_q  <= '0;
      idx_q   <= '0;
      vld_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      tile_q  <= tile_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    filt_d   = filt_q;
    tile_d   = tile_q;
    idx_d    = idx_q;
    issue    = (state_q == S_RUN) && !bus.hold && !bus.abort;
    new_addr = issue ? idx_q : '0;
    vld_d    = {vld_q[LAT-2:0], issue};
    addr_d   = {addr_q[LAT-2:0], new_addr};

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) state_d = S_RUN;
      end
      S_RUN: begin
        if (issue) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DRAIN;
            filt_d  = '0;
            tile_d  = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + OUT_W'(1);
            if (tile_q == TILE_LAST) begin
              tile_d = '0;
              filt_d = filt_q + FILT_W'(1);
            end else begin
              tile_d = tile_q + TILE_W'(1);
            end
          end
        end
      end
      // The write leaving the pipe this cycle is the last one when nothing sits behind it.
      S_DRAIN: begin
        if (vld_q[LAT-2:0] == '0) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.abort) begin
      state_d = S_IDLE;
      filt_d  = '0;
      tile_d  = '0;
      idx_d   = '0;
      vld_d   = '0;
      addr_d  = '0;
    end
  end

  assign bus.busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done          = (state_q == S_DONE);
  assign bus.in_rd_en      = issue;
  assign bus.param_rd_en   = issue;
  assign bus.in_rd_addr    = tile_q;
  assign bus.param_rd_addr = filt_q;
  assign bus.out_wr_en     = vld_q[LAT-1];
  assign bus.out_wr_addr   = addr_q[LAT-1];
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomized scoreboard bench for conv_layer_sequencer (3x5, LAT=4) plus a
// directed single-token pass on a 1x1, LAT=2 instance.
module tb_conv_layer_sequencer;
  localparam int NF    = 3;
  localparam int NT    = 5;
  localparam int LAT   = 4;
  localparam int TOTAL = NF * NT;

  logic clk_PL = 1'b0;
  always #5 clk_PL = ~clk_PL;

  logic rst_n  = 1'b0;
  logic rst2_n = 1'b0;

  conv_layer_sequencer_if #(.NUM_FILTERS(NF), .NUM_TILES(NT)) bus ();
  conv_layer_sequencer_if #(.NUM_FILTERS(1), .NUM_TILES(1)) bus2 ();

  conv_layer_sequencer #(.NUM_FILTERS(NF), .NUM_TILES(NT), .LAT(LAT)) dut (
    .clk_PL (clk_PL),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  conv_layer_sequencer #(.NUM_FILTERS(1), .NUM_TILES(1), .LAT(2)) dut_small (
    .clk_PL (clk_PL),
    .rst_n  (rst2_n),
    .bus    (bus2)
  );

  typedef struct {int cyc; int addr;} wr_t;
  typedef struct {int cyc; bit issue; int fa; int ta; bit busy; bit done;} cyc_t;

  wr_t  wq[$];
  cyc_t cq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_done = 0;

  // reference model: a pass is a run of TOTAL tokens numbered 0..TOTAL-1
  bit m_run      = 1'b0;
  int m_next     = 0;
  int m_done_due = -1;

  always @(posedge clk_PL) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit s, input bit h, input bit a, input bit r);
    cyc_t e;
    bit   idle;
    @(posedge clk_PL);
    #1;
    bus.start = s;
    bus.hold  = h;
    bus.abort = a;
    rst_n     = r;
    idle    = !m_run && (m_done_due < cyc);
    e.cyc   = cyc;
    e.issue = m_run && !h && !a;
    e.busy  = m_run || (m_done_due > cyc);
    e.done  = (m_done_due == cyc);
    e.fa    = m_next / NT;
    e.ta    = m_next % NT;
    cq.push_back(e);
    if (e.issue) begin
      wq.push_back('{cyc + LAT, m_next});
      if (m_next == TOTAL - 1) begin
        m_run      = 1'b0;
        m_next     = 0;
        m_done_due = cyc + LAT + 1;
      end else begin
        m_next++;
      end
    end
    if (!r || a) begin
      m_run      = 1'b0;
      m_next     = 0;
      m_done_due = -1;
      while (wq.size() > 0 && wq[$].cyc > cyc) void'(wq.pop_back());
    end else if (s && idle) begin
      m_run  = 1'b1;
      m_next = 0;
    end
  endtask

  cyc_t me;
  wr_t  mw;
  bit   exp_wr;
  always @(negedge clk_PL) begin
    if (cq.size() > 0) begin
      me = cq.pop_front();
      chk("in_rd_en", bus.in_rd_en, me.issue);
      chk("param_rd_en", bus.param_rd_en, me.issue);
      chk("busy", bus.busy, me.busy);
      chk("done", bus.done, me.done);
      if (me.issue) begin
        chk("in_rd_addr", bus.in_rd_addr, me.ta);
        chk("param_rd_addr", bus.param_rd_addr, me.fa);
      end
      if (me.done && bus.done === 1'b1) n_done++;
      exp_wr = (wq.size() > 0) && (wq[0].cyc == cyc);
      chk("out_wr_en", bus.out_wr_en, exp_wr);
      if (exp_wr) begin
        mw = wq.pop_front();
        if (bus.out_wr_en === 1'b1) chk("out_wr_addr", bus.out_wr_addr, mw.addr);
      end
    end
  end

  initial begin
    bus.start  = 1'b0;
    bus.hold   = 1'b0;
    bus.abort  = 1'b0;
    bus2.start = 1'b0;
    bus2.hold  = 1'b0;
    bus2.abort = 1'b0;

    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("reset_out_wr_en", bus.out_wr_en, 0);
    rst2_n = 1'b1;

    // clean pass, then a held pass, then start+abort in IDLE and start while busy
    drive(1, 0, 0, 1);
    repeat (TOTAL + LAT + 3) drive(0, 0, 0, 1);
    drive(1, 0, 0, 1);
    for (int i = 0; i < TOTAL + LAT + 8; i++) drive(i == 3, (i % 4) == 1, 0, 1);
    drive(1, 0, 1, 1);
    drive(0, 0, 0, 1);
    // abort mid-run, restart, then reset (with start) mid-drain
    drive(1, 0, 0, 1);
    repeat (4) drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    drive(1, 0, 0, 1);
    repeat (TOTAL + 1) drive(0, 0, 0, 1);
    drive(1, 0, 0, 0);
    repeat (LAT + 3) drive(0, 0, 0, 1);

    for (int i = 0; i < 2500; i++)
      drive(($urandom % 6) == 0, ($urandom % 4) == 0, ($urandom % 60) == 0, ($urandom % 150) != 0);
    repeat (TOTAL + LAT + 4) drive(0, 0, 0, 1);

    @(negedge clk_PL);
    chk("writes_drained", wq.size(), 0);
    chk("passes_completed", n_done > 0, 1);

    // single-token pass: issue rel1, write rel3 at addr 0, done rel4
    @(posedge clk_PL);
    #1 bus2.start = 1'b1;
    @(posedge clk_PL);
    #1 bus2.start = 1'b0;
    for (int rel = 1; rel <= 6; rel++) begin
      @(negedge clk_PL);
      chk("small_in_rd_en", bus2.in_rd_en, rel == 1);
      chk("small_out_wr_en", bus2.out_wr_en, rel == 3);
      chk("small_done", bus2.done, rel == 4);
      chk("small_busy", bus2.busy, rel >= 1 && rel <= 3);
      if (rel == 3) chk("small_out_wr_addr", bus2.out_wr_addr, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
